rf_2p_lane: RTL



---
 rtl/rf_2p_lane.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rf_2p_lane.sv
// Two-port lane-addressable register file with SIZE parallel channels, write-first
// bypass, optional output register and a zeroing init sequencer after reset/clear.
module rf_2p_lane #(
  parameter int WORDWD = 32,
  parameter int DWD    = 32,
  parameter int LANEWD = 16,
  parameter int SIZE   = 1,
  parameter int OREG   = 0,
  parameter int AWD    = $clog2(WORDWD * (DWD / LANEWD))
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_narrow,
  input  logic                i_clear,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [AWD-1:0]      i_raddr,
  input  logic [AWD-1:0]      i_waddr,
  input  logic [DWD*SIZE-1:0] i_wdata,
  output logic [DWD*SIZE-1:0] o_rdata,
  output logic                o_rvalid,
  output logic                o_ready,
  output logic                o_state
);
  localparam int NLANE = DWD / LANEWD;
  localparam int LW    = $clog2(NLANE);
  localparam int CW    = (WORDWD > 1) ? $clog2(WORDWD) : 1;

  // Handshake: a read/write is taken on a clock edge where it is high while
  // o_ready is high and i_clear is low; otherwise it is silently dropped.
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DWD*SIZE-1:0]   mem [WORDWD];

  logic [AWD-1:0]        wword, rword, wlane, rlane;
  logic [CW-1:0]         wi, ri;
  logic                  w_ok, r_ok, wr_acc, rd_acc;
  logic [DWD*SIZE-1:0]   wr_word, rd_word, rd_sel;

  assign o_state = state;

  assign wword  = i_narrow ? (i_waddr >> LW) : i_waddr;
  assign rword  = i_narrow ? (i_raddr >> LW) : i_raddr;
  assign wlane  = i_waddr & AWD'(NLANE - 1);
  assign rlane  = i_raddr & AWD'(NLANE - 1);
  assign w_ok   = 32'(wword) < 32'(WORDWD);
  assign r_ok   = 32'(rword) < 32'(WORDWD);
  assign wi     = wword[CW-1:0];
  assign ri     = rword[CW-1:0];
  assign wr_acc = (state == RUN) && i_write && !i_clear && w_ok;
  assign rd_acc = (state == RUN) && i_read && !i_clear;

  // Post-write image of the addressed word: selected lanes replaced, rest kept.
  always_comb begin
    wr_word = mem[wi];
    for (int j = 0; j < SIZE; j++) begin
      for (int l = 0; l < NLANE; l++) begin
        if (!i_narrow)
          wr_word[j*DWD+l*LANEWD +: LANEWD] = i_wdata[j*DWD+l*LANEWD +: LANEWD];
        else if (wlane == AWD'(l))
          wr_word[j*DWD+l*LANEWD +: LANEWD] = i_wdata[j*DWD +: LANEWD];
      end
    end
  end

  always_comb begin
    rd_word = (wr_acc && r_ok && (rword == wword)) ? wr_word : mem[ri];
    rd_sel  = '0;
    if (r_ok) begin
      for (int j = 0; j < SIZE; j++) begin
        if (!i_narrow) begin
          rd_sel[j*DWD +: DWD] = rd_word[j*DWD +: DWD];
        end else begin
          for (int l = 0; l < NLANE; l++) begin
            if (rlane == AWD'(l))
              rd_sel[j*DWD +: LANEWD] = rd_word[j*DWD+l*LANEWD +: LANEWD];
          end
        end
      end
    end
  end

  // Storage is deliberately not reset; INIT zeroes it one word per cycle.
  always_ff @(posedge i_clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wr_acc)
      mem[wi] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (i_clear) begin
            cnt <= '0;
          end else if (cnt == CW'(WORDWD - 1)) begin
            state   <= RUN;
            cnt     <= '0;
            o_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (i_clear) begin
            state   <= INIT;
            cnt     <= '0;
            o_ready <= 1'b0;
          end
        end
        default: begin
          state   <= INIT;
          cnt     <= '0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

  logic                s1_v;
  logic [DWD*SIZE-1:0] s1_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= rd_acc;
      if (rd_acc) s1_d <= rd_sel;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic                s2_v;
      logic [DWD*SIZE-1:0] s2_d;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s2_v <= 1'b0;
          s2_d <= '0;
        end else begin
          s2_v <= s1_v;
          if (s1_v) s2_d <= s1_d;
        end
      end
      assign o_rvalid = s2_v;
      assign o_rdata  = s2_d;
    end else begin : g_direct
      assign o_rvalid = s1_v;
      assign o_rdata  = s1_d;
    end
  endgenerate

endmodule
